phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: traffic-phase FSM with 1 Hz countdown, actuated green
// extension/rest, night flash and manual all-red hold. All outputs registered.
module phase_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [1:0] mode_sel,
  input  logic       veh_ns,
  input  logic       veh_ew,
  output logic [3:0] phase_id,
  output logic [7:0] time_left,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       phase_start
);

  localparam logic [1:0] MODE_FIXED  = 2'b00;
  localparam logic [1:0] MODE_ACT    = 2'b01;
  localparam logic [1:0] MODE_FLASH  = 2'b10;
  localparam logic [1:0] MODE_ALLRED = 2'b11;

  localparam logic [7:0] T_GREEN   = 8'd20;
  localparam logic [7:0] T_YELLOW  = 8'd3;
  localparam logic [7:0] T_ALLRED  = 8'd2;
  localparam logic [7:0] T_ACT_MIN = 8'd8;
  localparam logic [7:0] T_ACT_EXT = 8'd3;
  localparam logic [7:0] T_ACT_MAX = 8'd40;

  typedef enum logic [3:0] {
    S_NS_GREEN  = 4'd0,
    S_NS_YELLOW = 4'd1,
    S_ALLRED_A  = 4'd2,
    S_EW_GREEN  = 4'd3,
    S_EW_YELLOW = 4'd4,
    S_ALLRED_B  = 4'd5,
    S_FLASH     = 4'd6,
    S_HOLD      = 4'd7
  } phase_t;

  phase_t     phase_q, phase_d;
  logic [7:0] tl_q, tl_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] g_elapsed_q, g_elapsed_d;
  logic       blink_q, blink_d;
  logic       start_q, start_d;
  logic [2:0] ns_lamp_q, ns_lamp_d;
  logic [2:0] ew_lamp_q, ew_lamp_d;

  logic       is_green_s, act_green_s, own_s, cross_s, ext_ok_s;
  phase_t     next_phase_s;

  // Successor in the normal six-phase ring; special phases fall back to ALLRED_B.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      S_NS_GREEN:  next_phase = S_NS_YELLOW;
      S_NS_YELLOW: next_phase = S_ALLRED_A;
      S_ALLRED_A:  next_phase = S_EW_GREEN;
      S_EW_GREEN:  next_phase = S_EW_YELLOW;
      S_EW_YELLOW: next_phase = S_ALLRED_B;
      S_ALLRED_B:  next_phase = S_NS_GREEN;
      default:     next_phase = S_ALLRED_B;
    endcase
  endfunction

  // Load value for a phase; green length depends on the mode seen at load.
  function automatic logic [7:0] phase_duration(input phase_t p, input logic act);
    case (p)
      S_NS_GREEN, S_EW_GREEN:   phase_duration = act ? T_ACT_MIN : T_GREEN;
      S_NS_YELLOW, S_EW_YELLOW: phase_duration = T_YELLOW;
      S_ALLRED_A, S_ALLRED_B:   phase_duration = T_ALLRED;
      default:                  phase_duration = 8'd0;
    endcase
  endfunction

  // Lamp pattern {ns_rgy, ew_rgy}, each as {red,yellow,green}.
  function automatic logic [5:0] lamps_for(input phase_t p, input logic blink);
    case (p)
      S_NS_GREEN:  lamps_for = {3'b001, 3'b100};
      S_NS_YELLOW: lamps_for = {3'b010, 3'b100};
      S_EW_GREEN:  lamps_for = {3'b100, 3'b001};
      S_EW_YELLOW: lamps_for = {3'b100, 3'b010};
      S_FLASH:     lamps_for = {1'b0, blink, 1'b0, blink, 1'b0, 1'b0};
      default:     lamps_for = {3'b100, 3'b100};
    endcase
  endfunction

  // Decode served/opposing sensors and the extension cap for the current green.
  always_comb begin
    is_green_s   = (phase_q == S_NS_GREEN) || (phase_q == S_EW_GREEN);
    act_green_s  = is_green_s && (mode_q == MODE_ACT);
    own_s        = (phase_q == S_NS_GREEN) ? veh_ns : veh_ew;
    cross_s      = (phase_q == S_NS_GREEN) ? veh_ew : veh_ns;
    ext_ok_s     = ({1'b0, g_elapsed_q} + {1'b0, T_ACT_EXT}) < {1'b0, T_ACT_MAX};
    next_phase_s = next_phase(phase_q);
  end

  // Next-state: override modes first, then the tick-driven countdown.
  always_comb begin
    phase_d     = phase_q;
    tl_d        = tl_q;
    mode_d      = mode_q;
    g_elapsed_d = g_elapsed_q;
    blink_d     = blink_q;
    start_d     = 1'b0;
    case (mode_sel)
      MODE_FLASH: begin
        if (phase_q != S_FLASH) begin
          phase_d = S_FLASH;
          tl_d    = 8'd0;
          blink_d = 1'b0;
          start_d = 1'b1;
        end else if (tick_1hz) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      MODE_ALLRED: begin
        if (phase_q != S_HOLD) begin
          phase_d = S_HOLD;
          tl_d    = 8'd0;
          start_d = 1'b1;
        end else begin
          phase_d = S_HOLD;
        end
      end
      default: begin
        if ((phase_q == S_FLASH) || (phase_q == S_HOLD)) begin
          // Leaving an override: clear the junction, a same-cycle tick is dropped.
          phase_d = S_ALLRED_B;
          tl_d    = T_ALLRED;
          mode_d  = mode_sel;
          start_d = 1'b1;
        end else if (tick_1hz) begin
          if (is_green_s) begin
            g_elapsed_d = (g_elapsed_q == 8'd255) ? 8'd255 : g_elapsed_q + 8'd1;
          end else begin
            g_elapsed_d = g_elapsed_q;
          end
          if (act_green_s && own_s && (tl_q <= T_ACT_EXT) && ext_ok_s) begin
            tl_d = T_ACT_EXT;
          end else if (act_green_s && (tl_q == 8'd1) && !cross_s) begin
            tl_d = 8'd1;
          end else if (tl_q > 8'd1) begin
            tl_d = tl_q - 8'd1;
          end else begin
            phase_d = next_phase_s;
            mode_d  = mode_sel;
            tl_d    = phase_duration(next_phase_s, mode_sel == MODE_ACT);
            start_d = 1'b1;
            if ((next_phase_s == S_NS_GREEN) || (next_phase_s == S_EW_GREEN)) begin
              g_elapsed_d = 8'd0;
            end else begin
              g_elapsed_d = g_elapsed_q;
            end
          end
        end else begin
          tl_d = tl_q;
        end
      end
    endcase
    {ns_lamp_d, ew_lamp_d} = lamps_for(phase_d, blink_d);
  end

  // State and output registers with synchronous reset to the all-red clearance.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= S_ALLRED_B;
      tl_q        <= T_ALLRED;
      mode_q      <= MODE_FIXED;
      g_elapsed_q <= 8'd0;
      blink_q     <= 1'b0;
      start_q     <= 1'b0;
      ns_lamp_q   <= 3'b100;
      ew_lamp_q   <= 3'b100;
    end else begin
      phase_q     <= phase_d;
      tl_q        <= tl_d;
      mode_q      <= mode_d;
      g_elapsed_q <= g_elapsed_d;
      blink_q     <= blink_d;
      start_q     <= start_d;
      ns_lamp_q   <= ns_lamp_d;
      ew_lamp_q   <= ew_lamp_d;
    end
  end

  assign phase_id    = phase_q;
  assign time_left   = tl_q;
  assign ns_lamp     = ns_lamp_q;
  assign ew_lamp     = ew_lamp_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       veh_ns = 1'b0;
  logic       veh_ew = 1'b0;
  logic [3:0] phase_id;
  logic [7:0] time_left;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       phase_start;

  int n_cmp = 0;
  int n_bad = 0;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_sel(mode_sel),
    .veh_ns(veh_ns), .veh_ew(veh_ew), .phase_id(phase_id),
    .time_left(time_left), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with tick high; outputs sampled 1 time unit after the edge.
  task automatic do_tick();
    @(negedge clk);
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m, input logic t);
    @(negedge clk);
    mode_sel = m;
    tick_1hz = t;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ph, input logic [7:0] tl,
                           input logic [2:0] ns, input logic [2:0] ew);
    chk({tag, ".phase"}, phase_id, ph);
    chk({tag, ".tl"}, time_left, tl);
    chk({tag, ".ns"}, ns_lamp, ns);
    chk({tag, ".ew"}, ew_lamp, ew);
  endtask

  int cnt;

  initial begin
    // Reset state
    idle(2);
    chk_state("rst", 4'd5, 8'd2, 3'b100, 3'b100);
    chk("rst.start", phase_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Fixed-time cycle
    do_tick();
    chk("fx.tl1", time_left, 8'd1);
    chk("fx.nostart", phase_start, 1'b0);
    do_tick();
    chk_state("fx.nsg", 4'd0, 8'd20, 3'b001, 3'b100);
    chk("fx.start", phase_start, 1'b1);
    idle(1);
    chk("fx.startpulse", phase_start, 1'b0);
    ticks(19);
    chk_state("fx.nsg_end", 4'd0, 8'd1, 3'b001, 3'b100);
    do_tick();
    chk_state("fx.nsy", 4'd1, 8'd3, 3'b010, 3'b100);
    ticks(3);
    chk_state("fx.ara", 4'd2, 8'd2, 3'b100, 3'b100);
    ticks(2);
    chk_state("fx.ewg", 4'd3, 8'd20, 3'b100, 3'b001);
    ticks(8);
    chk("fx.ewg12", time_left, 8'd12);

    // Flash override mid EW green
    set_mode(2'b10, 1'b0);
    chk_state("fl.entry", 4'd6, 8'd0, 3'b000, 3'b000);
    chk("fl.start", phase_start, 1'b1);
    do_tick();
    chk_state("fl.blink1", 4'd6, 8'd0, 3'b010, 3'b100);
    do_tick();
    chk_state("fl.blink0", 4'd6, 8'd0, 3'b000, 3'b000);
    // Exit with a same-cycle tick: the tick is dropped
    set_mode(2'b00, 1'b1);
    chk_state("fl.exit", 4'd5, 8'd2, 3'b100, 3'b100);
    chk("fl.exitstart", phase_start, 1'b1);
    ticks(2);
    chk_state("fl.resume", 4'd0, 8'd20, 3'b001, 3'b100);

    // Fixed->actuated switch mid NS green
    ticks(10);
    chk("sw.tl10", time_left, 8'd10);
    set_mode(2'b01, 1'b0);
    ticks(9);
    chk_state("sw.nsg_fixed", 4'd0, 8'd1, 3'b001, 3'b100);
    do_tick();
    chk("sw.nsy", phase_id, 4'd1);
    ticks(5);
    chk_state("sw.ewg_act", 4'd3, 8'd8, 3'b100, 3'b001);

    // Actuated rest-in-green with no demand
    ticks(7);
    chk("act.rest_tl", time_left, 8'd1);
    ticks(5);
    chk_state("act.rest", 4'd3, 8'd1, 3'b100, 3'b001);
    veh_ns = 1'b1;
    do_tick();
    chk_state("act.adv", 4'd4, 8'd3, 3'b100, 3'b010);
    ticks(5);
    chk_state("act.nsg", 4'd0, 8'd8, 3'b001, 3'b100);

    // Actuated extension capped by the maximum green
    veh_ew = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      cnt = i;
      if (i == 10) chk("cap.pinned", time_left, 8'd3);
      if (phase_id != 4'd0) break;
    end
    chk("cap.len", cnt, 40);
    chk("cap.phase", phase_id, 4'd1);

    // All-red hold and direct hold<->flash changes; mode change beats tick
    set_mode(2'b11, 1'b1);
    chk_state("hold.entry", 4'd7, 8'd0, 3'b100, 3'b100);
    chk("hold.start", phase_start, 1'b1);
    set_mode(2'b10, 1'b1);
    chk_state("hold.toflash", 4'd6, 8'd0, 3'b000, 3'b000);
    set_mode(2'b11, 1'b0);
    chk("hold.back", phase_id, 4'd7);
    veh_ns = 1'b0;
    veh_ew = 1'b0;
    set_mode(2'b00, 1'b0);
    chk_state("hold.exit", 4'd5, 8'd2, 3'b100, 3'b100);

    // Reset with a tick during EW green
    ticks(2);
    chk("rr.nsg", time_left, 8'd20);
    ticks(25);
    chk_state("rr.ewg", 4'd3, 8'd20, 3'b100, 3'b001);
    ticks(5);
    @(negedge clk);
    rst = 1'b1;
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    chk_state("rr.reset", 4'd5, 8'd2, 3'b100, 3'b100);
    chk("rr.start", phase_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick_1hz = 1'b0;
    idle(1);
    chk("rr.hold_tl", time_left, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
